pipeline_hazard_unit: RTL and testbench
=======================================

Name: pipeline_hazard_unit

Overview:
Parametrised hazard controller for the 5-stage RV32I pipeline. It generates the next PC, per-stage write-enable and flush controls, and supports three hazard sources. Load-use stalls have a configurable bubble count. EX-stage redirects (branch/JAL/JALR) flush the pipeline. Data-memory wait states freeze the whole pipeline, with a watchdog timeout. It also keeps saturating stall and flush performance counters, and sits between the IF/ID/EX/MEM pipeline registers and the PC register.

Parameters:
DATA_WIDTH, 32, PC/data width
REG_W, 5, register address width
LOAD_USE_STALL, 1, bubbles per load-use hazard (1 = MEM->EX forwarding present, 2 = WB forwarding only); legal 1..3
MAX_MEM_WAIT, 15, consecutive frozen cycles before mem_timeout asserts
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
id_rs1  in  REG_W  ID source reg 1
id_rs2  in  REG_W  ID source reg 2
id_use_rs1  in  1  ID instr reads rs1
id_use_rs2  in  1  ID instr reads rs2
ex_mem_read  in  1  EX instr is a load
ex_rd  in  REG_W  EX destination reg
ex_jump  in  2  00 none, 01 branch, 10 JALR, 11 JAL
ex_branch_taken  in  1  branch condition true
ex_branch_target  in  DATA_WIDTH  PC+imm
ex_alu_result  in  DATA_WIDTH  JALR target
if_pc_plus_4  in  DATA_WIDTH  sequential PC
mem_req  in  1  MEM stage accessing data memory
mem_ready  in  1  data memory ack
next_pc  out  DATA_WIDTH  PC register D input
pc_write_en  out  1  PC load enable
ifid_write_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID insert NOP (addi x0,x0,0 / zero controls)
idex_write_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX zero control bits
exmem_write_en  out  1  EX/MEM load enable
mem_timeout  out  1  sticky watchdog flag
stall_count  out  CNT_W  cycles with pc_write_en=0
flush_count  out  CNT_W  redirects taken

Behaviour:
- Reset is synchronous, active-low, clock clk. While rstn=0: state=RUN, lu_cnt=0, wait_cnt=0, mem_timeout=0, both counters 0. Outputs are forced to pc_write_en=0, ifid_write_en=0, idex_write_en=0, exmem_write_en=0, ifid_flush=1, idex_flush=1, next_pc=if_pc_plus_4. A reset in any state aborts the state and all counts.
- Derived signals:
  - freeze = mem_req & ~mem_ready.
  - redirect = (ex_jump==01 & ex_branch_taken) | ex_jump==10 | ex_jump==11.
  - lu_hit = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- next_pc is combinational: ex_branch_target for 01-taken or 11; ex_alu_result with bit0 cleared for 10; else if_pc_plus_4.
- Priority is freeze > redirect > load-use.
- freeze (any state):
  - All write enables=0, both flushes=0.
  - State, lu_cnt and the pending redirect are held.
  - wait_cnt increments, saturating. When wait_cnt reaches MAX_MEM_WAIT, mem_timeout=1 (sticky until reset). The pipeline stays frozen; the unit does not abort.
  - wait_cnt clears on any non-freeze cycle.
- RUN, redirect:
  - pc_write_en=1, ifid_flush=1, idex_flush=1, all enables=1.
  - flush_count+1.
  - lu_hit is ignored because the ID instr is squashed.
- RUN, lu_hit (no redirect):
  - pc_write_en=0, ifid_write_en=0, idex_flush=1 (bubble), exmem_write_en=1.
  - If LOAD_USE_STALL>1: state->LU_STALL, lu_cnt<=LOAD_USE_STALL-1.
- RUN, otherwise: all enables=1, flushes=0.
- LU_STALL:
  - Same outputs as a RUN lu_hit cycle.
  - lu_cnt decrements each non-freeze cycle; at lu_cnt==1 it returns to RUN on the next edge.
  - EX holds a bubble, so redirect cannot occur here.
- stall_count increments (saturating at all-ones) every non-reset cycle with pc_write_en=0. flush_count saturates likewise.
- Latency: all controls are combinational from inputs and current state. State and counters update on the posedge clk.
- ex_rd==0 never stalls. id_use_rsX=0 masks that operand. A load to x5 followed by JAL (id_use_rs1=0, id_use_rs2=0) does not stall.

Test Plan:
1. Reset held 3 cycles, then release with no hazards -> during reset: pc_write_en=0, ifid_flush=1, counters 0. After release: all enables=1, next_pc=if_pc_plus_4.
2. LOAD_USE_STALL=1: EX lw x5, ID add x6,x5,x1 (id_use_rs1=1) -> exactly one cycle with pc_write_en=0, ifid_write_en=0, idex_flush=1. stall_count=1.
3. LOAD_USE_STALL=2, same stimulus -> two consecutive bubble cycles, then RUN. stall_count=2.
4. ex_jump=01, taken, target 0x100, with lu_hit simultaneously -> next_pc=0x100, ifid_flush=idex_flush=1, pc_write_en=1, no stall. flush_count=1.
5. JALR with ex_alu_result=0x203 -> next_pc=0x202. Branch not taken -> next_pc=if_pc_plus_4, no flush.
6. mem_req=1, mem_ready=0 for 20 cycles with MAX_MEM_WAIT=15 -> all enables=0 throughout, mem_timeout=1 from the 15th frozen cycle onward and remains 1 after mem_ready=1. A redirect pending during the freeze takes effect on the first ready cycle.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for the 5-stage RV32I pipeline. It selects the next PC, drives the
// stage enables and flushes, and keeps the memory-wait watchdog and stall/flush counters.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | normal issue; redirects and first load-use bubble decided here
//   LU_STALL | extra load-use bubbles remaining (lu_cnt_q counts them down)
module pipeline_hazard_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_W          = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int MAX_MEM_WAIT   = 15,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [REG_W-1:0]      id_rs1,
    input  logic [REG_W-1:0]      id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_W-1:0]      ex_rd,
    input  logic [1:0]            ex_jump,
    input  logic                  ex_branch_taken,
    input  logic [DATA_WIDTH-1:0] ex_branch_target,
    input  logic [DATA_WIDTH-1:0] ex_alu_result,
    input  logic [DATA_WIDTH-1:0] if_pc_plus_4,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] next_pc,
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic                  ifid_flush,
    output logic                  idex_write_en,
    output logic                  idex_flush,
    output logic                  exmem_write_en,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int                WAIT_W   = $clog2(MAX_MEM_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_MEM_WAIT);
    localparam logic [1:0]        LU_INIT  = 2'(LOAD_USE_STALL - 1);

    typedef enum logic {RUN, LU_STALL} state_t;

    state_t            state_q,     state_d;
    logic [1:0]        lu_cnt_q,    lu_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
    logic              timeout_q,   timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic freeze;
    logic redirect;
    logic lu_hit;
    logic take_redirect;

    assign freeze   = mem_req & ~mem_ready;
    assign redirect = ((ex_jump == 2'b01) & ex_branch_taken) | ex_jump[1];
    assign lu_hit   = ex_mem_read & (ex_rd != '0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        next_pc = if_pc_plus_4;
        if (rstn) begin
            if (((ex_jump == 2'b01) && ex_branch_taken) || (ex_jump == 2'b11)) begin
                next_pc = ex_branch_target;
            end else if (ex_jump == 2'b10) begin
                next_pc = {ex_alu_result[DATA_WIDTH-1:1], 1'b0};
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        lu_cnt_d       = lu_cnt_q;
        wait_cnt_d     = '0;
        timeout_d      = timeout_q;
        take_redirect  = 1'b0;
        pc_write_en    = 1'b1;
        ifid_write_en  = 1'b1;
        idex_write_en  = 1'b1;
        exmem_write_en = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;

        if (!rstn) begin
            pc_write_en    = 1'b0;
            ifid_write_en  = 1'b0;
            idex_write_en  = 1'b0;
            exmem_write_en = 1'b0;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            state_d        = RUN;
            lu_cnt_d       = '0;
            timeout_d      = 1'b0;
        end else if (freeze) begin
            // whole pipeline holds; EX keeps any redirect so it resolves once memory acks
            pc_write_en    = 1'b0;
            ifid_write_en  = 1'b0;
            idex_write_en  = 1'b0;
            exmem_write_en = 1'b0;
            wait_cnt_d     = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_d == WAIT_MAX) begin
                timeout_d = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (redirect) begin
                        ifid_flush    = 1'b1;
                        idex_flush    = 1'b1;
                        take_redirect = 1'b1;
                    end else if (lu_hit) begin
                        pc_write_en   = 1'b0;
                        ifid_write_en = 1'b0;
                        idex_flush    = 1'b1;
                        if (LOAD_USE_STALL > 1) begin
                            state_d  = LU_STALL;
                            lu_cnt_d = LU_INIT;
                        end
                    end
                end
                LU_STALL: begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    idex_flush    = 1'b1;
                    if (lu_cnt_q <= 2'd1) begin
                        state_d  = RUN;
                        lu_cnt_d = '0;
                    end else begin
                        lu_cnt_d = lu_cnt_q - 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!rstn) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_write_en && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (take_redirect && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= RUN;
            lu_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: u1 uses defaults, u2 uses two load-use
// bubbles and a 4-bit counter so stall-count saturation is reachable.
module tb_pipeline_hazard_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic [1:0]  ex_jump;
    logic [31:0] ex_branch_target, ex_alu_result, if_pc_plus_4;
    logic        mem_req, mem_ready;

    logic [31:0] npc1, npc2;
    logic        pcwe1, ifwe1, iffl1, idwe1, idfl1, exwe1, to1;
    logic        pcwe2, ifwe2, iffl2, idwe2, idfl2, exwe2, to2;
    logic [15:0] sc1, fc1;
    logic [3:0]  sc2, fc2;
    logic [5:0]  ctl1, ctl2;

    int checks = 0;
    int errors = 0;

    // bit order: pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush
    localparam logic [5:0] C_RUN   = 6'b111100;
    localparam logic [5:0] C_REDIR = 6'b111111;
    localparam logic [5:0] C_STALL = 6'b000101;
    localparam logic [5:0] M_STALL = 6'b110111;
    localparam logic [5:0] C_FRZ   = 6'b000000;
    localparam logic [5:0] C_RST   = 6'b000011;

    assign ctl1 = {pcwe1, ifwe1, idwe1, exwe1, iffl1, idfl1};
    assign ctl2 = {pcwe2, ifwe2, idwe2, exwe2, iffl2, idfl2};

    always #5 clk = ~clk;

    pipeline_hazard_unit u1 (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_jump(ex_jump), .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target), .ex_alu_result(ex_alu_result),
        .if_pc_plus_4(if_pc_plus_4), .mem_req(mem_req), .mem_ready(mem_ready),
        .next_pc(npc1), .pc_write_en(pcwe1), .ifid_write_en(ifwe1), .ifid_flush(iffl1),
        .idex_write_en(idwe1), .idex_flush(idfl1), .exmem_write_en(exwe1),
        .mem_timeout(to1), .stall_count(sc1), .flush_count(fc1)
    );

    pipeline_hazard_unit #(.LOAD_USE_STALL(2), .CNT_W(4)) u2 (
        .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_jump(ex_jump), .ex_branch_taken(ex_branch_taken),
        .ex_branch_target(ex_branch_target), .ex_alu_result(ex_alu_result),
        .if_pc_plus_4(if_pc_plus_4), .mem_req(mem_req), .mem_ready(mem_ready),
        .next_pc(npc2), .pc_write_en(pcwe2), .ifid_write_en(ifwe2), .ifid_flush(iffl2),
        .idex_write_en(idwe2), .idex_flush(idfl2), .exmem_write_en(exwe2),
        .mem_timeout(to2), .stall_count(sc2), .flush_count(fc2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_jump = 2'b00; ex_branch_taken = 1'b0;
        ex_branch_target = 32'h0; ex_alu_result = 32'h0; if_pc_plus_4 = 32'h0000_0044;
        mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic do_reset;
        idle();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        #1;
    endtask

    task automatic set_load_use;
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        id_rs2 = 5'd1; id_use_rs2 = 1'b1;
    endtask

    task automatic test_reset;
        idle();
        rstn = 1'b0;
        ex_jump = 2'b11; ex_branch_target = 32'h0000_0500;
        set_load_use();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ctl1 !== C_RST) begin
                errors++; $display("FAIL reset_ctl cyc%0d: got %b want %b", i, ctl1, C_RST);
            end
            checks++;
            if (npc1 !== 32'h0000_0044) begin
                errors++; $display("FAIL reset_next_pc: got %h want 00000044", npc1);
            end
            checks++;
            if ({sc1, fc1, to1} !== 33'd0) begin
                errors++; $display("FAIL reset_counts: got sc=%0d fc=%0d to=%b want 0", sc1, fc1, to1);
            end
        end
        idle();
        rstn = 1'b1;
        #1;
        checks++;
        if (ctl1 !== C_RUN || npc1 !== 32'h0000_0044) begin
            errors++; $display("FAIL release_run: got ctl=%b pc=%h want %b 00000044", ctl1, npc1, C_RUN);
        end
        step();
        checks++;
        if (sc1 !== 16'd0) begin
            errors++; $display("FAIL release_stall_cnt: got %0d want 0", sc1);
        end
    endtask

    task automatic test_load_use;
        do_reset();
        set_load_use();
        #1;
        checks++;
        if ((ctl1 & M_STALL) !== C_STALL || (ctl2 & M_STALL) !== C_STALL) begin
            errors++; $display("FAIL lu_first: got u1=%b u2=%b want %b", ctl1, ctl2, C_STALL);
        end
        step();
        ex_mem_read = 1'b0;  // bubble now in EX, dependent instr still in ID
        #1;
        checks++;
        if (ctl1 !== C_RUN) begin
            errors++; $display("FAIL lu1_resume: got %b want %b", ctl1, C_RUN);
        end
        checks++;
        if ((ctl2 & M_STALL) !== C_STALL) begin
            errors++; $display("FAIL lu2_second_bubble: got %b want %b", ctl2, C_STALL);
        end
        step();
        checks++;
        if (ctl2 !== C_RUN) begin
            errors++; $display("FAIL lu2_resume: got %b want %b", ctl2, C_RUN);
        end
        checks++;
        if (sc1 !== 16'd1 || sc2 !== 4'd2) begin
            errors++; $display("FAIL lu_stall_cnt: got u1=%0d u2=%0d want 1 2", sc1, sc2);
        end
    endtask

    task automatic test_lu_masks;
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        #1;
        checks++;
        if (ctl1 !== C_RUN || ctl2 !== C_RUN) begin
            errors++; $display("FAIL lu_rd_x0: got u1=%b u2=%b want %b", ctl1, ctl2, C_RUN);
        end
        step();
        ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd5; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        #1;
        checks++;
        if (ctl1 !== C_RUN || ctl2 !== C_RUN) begin
            errors++; $display("FAIL lu_masked_jal: got u1=%b u2=%b want %b", ctl1, ctl2, C_RUN);
        end
        step();
        id_rs1 = 5'd7; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        #1;
        checks++;
        if ((ctl1 & M_STALL) !== C_STALL) begin
            errors++; $display("FAIL lu_rs2_hit: got %b want %b", ctl1, C_STALL);
        end
        step();
        checks++;
        if (sc1 !== 16'd1) begin
            errors++; $display("FAIL lu_mask_stall_cnt: got %0d want 1", sc1);
        end
    endtask

    task automatic test_redirect;
        do_reset();
        set_load_use();
        ex_jump = 2'b01; ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0100;
        #1;
        checks++;
        if (npc1 !== 32'h0000_0100 || ctl1 !== C_REDIR || ctl2 !== C_REDIR) begin
            errors++; $display("FAIL br_taken: got pc=%h u1=%b u2=%b want 00000100 %b", npc1, ctl1, ctl2, C_REDIR);
        end
        step();
        idle();
        #1;
        checks++;
        if (fc1 !== 16'd1 || sc1 !== 16'd0 || fc2 !== 4'd1 || sc2 !== 4'd0) begin
            errors++; $display("FAIL br_counts: got fc=%0d sc=%0d fc2=%0d sc2=%0d want 1 0 1 0", fc1, sc1, fc2, sc2);
        end
        checks++;
        if (ctl2 !== C_RUN) begin
            errors++; $display("FAIL br_no_lu_state: got %b want %b", ctl2, C_RUN);
        end
    endtask

    task automatic test_jump_targets;
        do_reset();
        ex_jump = 2'b10; ex_alu_result = 32'h0000_0203;
        #1;
        checks++;
        if (npc1 !== 32'h0000_0202 || ctl1 !== C_REDIR) begin
            errors++; $display("FAIL jalr: got pc=%h ctl=%b want 00000202 %b", npc1, ctl1, C_REDIR);
        end
        step();
        ex_jump = 2'b01; ex_branch_taken = 1'b0; ex_branch_target = 32'h0000_0100;
        #1;
        checks++;
        if (npc1 !== 32'h0000_0044 || ctl1 !== C_RUN) begin
            errors++; $display("FAIL br_not_taken: got pc=%h ctl=%b want 00000044 %b", npc1, ctl1, C_RUN);
        end
        step();
        ex_jump = 2'b11; ex_branch_target = 32'h0000_0300;
        #1;
        checks++;
        if (npc1 !== 32'h0000_0300 || ctl1 !== C_REDIR) begin
            errors++; $display("FAIL jal: got pc=%h ctl=%b want 00000300 %b", npc1, ctl1, C_REDIR);
        end
        step();
        idle();
        #1;
        checks++;
        if (fc1 !== 16'd2) begin
            errors++; $display("FAIL jump_flush_cnt: got %0d want 2", fc1);
        end
    endtask

    task automatic test_freeze;
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        ex_jump = 2'b11; ex_branch_target = 32'h0000_0400;
        for (int i = 1; i <= 20; i++) begin
            #1;
            checks++;
            if (ctl1 !== C_FRZ || ctl2 !== C_FRZ) begin
                errors++; $display("FAIL freeze_ctl cyc%0d: got u1=%b u2=%b want %b", i, ctl1, ctl2, C_FRZ);
            end
            step();
            if (i == 14) begin
                checks++;
                if (to1 !== 1'b0) begin
                    errors++; $display("FAIL timeout_early: got %b want 0", to1);
                end
            end else if (i >= 15) begin
                checks++;
                if (to1 !== 1'b1 || to2 !== 1'b1) begin
                    errors++; $display("FAIL timeout_set cyc%0d: got %b %b want 1", i, to1, to2);
                end
            end
        end
        checks++;
        if (sc1 !== 16'd20 || sc2 !== 4'd15 || fc1 !== 16'd0) begin
            errors++; $display("FAIL freeze_counts: got sc=%0d sc2=%0d fc=%0d want 20 15 0", sc1, sc2, fc1);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl1 !== C_REDIR || npc1 !== 32'h0000_0400) begin
            errors++; $display("FAIL pending_redirect: got ctl=%b pc=%h want %b 00000400", ctl1, npc1, C_REDIR);
        end
        step();
        idle();
        #1;
        checks++;
        if (fc1 !== 16'd1 || to1 !== 1'b1 || sc1 !== 16'd20) begin
            errors++; $display("FAIL after_freeze: got fc=%0d to=%b sc=%0d want 1 1 20", fc1, to1, sc1);
        end
        do_reset();
        checks++;
        if (to1 !== 1'b0) begin
            errors++; $display("FAIL timeout_clear: got %b want 0", to1);
        end
    endtask

    task automatic test_freeze_in_stall;
        do_reset();
        set_load_use();
        step();
        ex_mem_read = 1'b0;
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        checks++;
        if (ctl2 !== C_FRZ) begin
            errors++; $display("FAIL stall_freeze: got %b want %b", ctl2, C_FRZ);
        end
        step();
        step();
        mem_ready = 1'b1;
        #1;
        checks++;
        if ((ctl2 & M_STALL) !== C_STALL) begin
            errors++; $display("FAIL stall_held: got %b want %b", ctl2, C_STALL);
        end
        step();
        checks++;
        if (ctl2 !== C_RUN || sc2 !== 4'd4) begin
            errors++; $display("FAIL stall_exit: got ctl=%b sc=%0d want %b 4", ctl2, sc2, C_RUN);
        end
        set_load_use();
        step();
        idle();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        #1;
        checks++;
        if (ctl2 !== C_RUN || sc2 !== 4'd0) begin
            errors++; $display("FAIL reset_abort: got ctl=%b sc=%0d want %b 0", ctl2, sc2, C_RUN);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_lu_masks();
        test_redirect();
        test_jump_targets();
        test_freeze();
        test_freeze_in_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
